program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 23 ++
 rtl/loader_word_packer.sv | 33 +++
 rtl/program_loader.sv | 145 ++++++++++++++
 tb/tb_program_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared states and framing constants for program_loader
package program_loader_pkg;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    // A load holds the CPU in every state between acceptance and completion, including ERROR.
    function automatic logic busy_state(input state_t s);
        return (s != IDLE) && (s != DONE);
    endfunction

endpackage

// File: rtl/loader_word_packer.sv
// rtl/loader_word_packer.sv - little-endian byte-to-word assembler with byte counter
module loader_word_packer
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_push,
    input  logic [7:0]  i_byte,
    output logic        o_last,
    output logic [31:0] o_word
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] r_cnt;
    logic [23:0]      r_shift;

    // Only the three earlier bytes are stored; the word completes with the byte being pushed.
    assign o_word = {i_byte, r_shift};
    assign o_last = (r_cnt == CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_push) begin
            r_shift <= o_word[31:8];
            r_cnt   <= o_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program loader; PROGRAM_LOADER_CHECKSUM_EN adds an XOR checksum byte
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_rx_ready;
    logic              r_mem_w_en;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_mem_data;
    logic              r_hold;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W:0]   r_word_count;
    logic [7:0]        r_len_lo;

    logic              w_accept;
    logic              w_start;
    logic [15:0]       w_len;
    logic [ADDR_W:0]   w_addr_next;
    logic              w_more;
    logic              w_pk_last;
    logic [31:0]       w_pk_word;

    assign w_accept    = rx_valid && r_rx_ready;
    assign w_start     = load_start && ((r_state == IDLE) || (r_state == ERROR));
    assign w_len       = {rx_data, r_len_lo};
    assign w_addr_next = {1'b0, r_addr} + {{ADDR_W{1'b0}}, 1'b1};
    assign w_more      = (w_addr_next < r_word_count);

    loader_word_packer u_packer (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_start),
        .i_push (w_accept && (r_state == DATA)),
        .i_byte (rx_data),
        .o_last (w_pk_last),
        .o_word (w_pk_word)
    );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_csum <= '0;
        end else if (w_accept && (r_state == DATA)) begin
            r_csum <= r_csum ^ rx_data;
        end
    end

    function automatic logic ready_state(input state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHECK);
    endfunction
`else
    function automatic logic ready_state(input state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA);
    endfunction
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:   if (load_start) w_next_state = LEN_LO;
            LEN_LO: if (w_accept) w_next_state = LEN_HI;
            LEN_HI: begin
                if (w_accept) begin
                    if ({16'd0, w_len} > MAX_WORDS) w_next_state = ERROR;
                    else if (w_len == 16'd0)        w_next_state = CHECK;
                    else                            w_next_state = DATA;
                end
            end
            DATA:   if (w_accept && w_pk_last) w_next_state = WRITE;
            WRITE:  w_next_state = w_more ? DATA : CHECK;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHECK:  if (w_accept) w_next_state = (rx_data == r_csum) ? DONE : ERROR;
`else
            CHECK:  w_next_state = DONE;
`endif
            DONE:   w_next_state = IDLE;
            ERROR:  if (load_start) w_next_state = LEN_LO;
            default: w_next_state = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rx_ready   <= 1'b0;
            r_mem_w_en   <= 1'b0;
            r_addr       <= '0;
            r_mem_data   <= '0;
            r_hold       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_word_count <= '0;
            r_len_lo     <= '0;
        end else begin
            r_state    <= w_next_state;
            r_rx_ready <= ready_state(w_next_state);
            r_mem_w_en <= (w_next_state == WRITE);
            r_hold     <= busy_state(w_next_state);
            r_done     <= (w_next_state == DONE);
            r_err      <= (w_next_state == ERROR);
            if (w_start) r_addr <= '0;
            if (w_accept && (r_state == LEN_LO)) r_len_lo <= rx_data;
            if (w_accept && (r_state == LEN_HI)) r_word_count <= (ADDR_W+1)'(w_len);
            if (w_accept && (r_state == DATA) && w_pk_last) r_mem_data <= w_pk_word;
            // The index stops on the last word so it never wraps past a full memory.
            if ((r_state == WRITE) && w_more) r_addr <= w_addr_next[ADDR_W-1:0];
        end
    end

    assign rx_ready   = r_rx_ready;
    assign mem_w_en   = r_mem_w_en;
    assign mem_addr   = r_addr;
    assign mem_data   = r_mem_data;
    assign cpu_hold   = r_hold;
    assign busy       = r_hold;
    assign done       = r_done;
    assign err        = r_err;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_count;

    int          n_total = 0;
    int          n_bad   = 0;
    int          done_cnt = 0;
    int          wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  stream[$];

    program_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .mem_w_en   (mem_w_en),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_w_en) begin
            wr_addr.push_back(int'(mem_addr));
            wr_data.push_back(mem_data);
        end
        if (done) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = rx_ready;
            step();
            n++;
        end
        if (!ok) check_eq("rx_timeout", 32'(ok), 32'd1);
        rx_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic send_stream(input int gap);
        foreach (stream[i]) send_byte(stream[i], gap);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(done), 32'd1);
        check_eq({tag, "_busy"}, {30'd0, busy, cpu_hold}, 32'd0);
        step();
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq(tag, {rx_ready, mem_w_en, cpu_hold, busy, done, err}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        repeat (2) step();
        check_idle_outputs("rst_flags");
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_data", mem_data, 32'd0);
        check_eq("rst_wcnt", 32'(word_count), 32'd0);
        rst = 1'b0;
        step();

        // Two-word load with an ignored load_start in LEN_HI.
        clear_log();
        start_load();
        check_eq("start_flags", {rx_ready, busy, cpu_hold, err}, 32'hE);
        send_byte(8'h02, 0);
        start_load();
        stream = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_stream(0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'h88, 0);
`endif
        wait_done("two_done");
        check_eq("two_nwr", 32'(wr_data.size()), 32'd2);
        if (wr_data.size() == 2) begin
            check_eq("two_a0", 32'(wr_addr[0]), 32'd0);
            check_eq("two_d0", wr_data[0], 32'h44332211);
            check_eq("two_a1", 32'(wr_addr[1]), 32'd1);
            check_eq("two_d1", wr_data[1], 32'h88776655);
        end
        check_eq("two_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("two_wcnt", 32'(word_count), 32'd2);
        check_idle_outputs("two_idle");

        // Zero-length load.
        clear_log();
        start_load();
        stream = '{8'h00, 8'h00};
        send_stream(0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        wait_done("zero_done");
        check_eq("zero_nwr", 32'(wr_data.size()), 32'd0);
        check_eq("zero_wcnt", 32'(word_count), 32'd0);

        // Oversize length goes to ERROR and stays there.
        clear_log();
        start_load();
        stream = '{8'h01, 8'h08};
        send_stream(0);
        check_eq("big_flags", {rx_ready, err, cpu_hold, busy}, 32'h7);
        repeat (3) step();
        check_eq("big_hold", {rx_ready, err, cpu_hold, busy, done}, 32'hE);
        check_eq("big_nwr", 32'(wr_data.size()), 32'd0);
        check_eq("big_wcnt", 32'(word_count), 32'h801);

        // Restart from ERROR with a one-word load.
        start_load();
        check_eq("restart_flags", {err, rx_ready}, 32'h1);
        stream = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_stream(0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        wait_done("restart_done");
        check_eq("restart_nwr", 32'(wr_data.size()), 32'd1);
        if (wr_data.size() == 1) begin
            check_eq("restart_a0", 32'(wr_addr[0]), 32'd0);
            check_eq("restart_d0", wr_data[0], 32'hDDCCBBAA);
        end

        // Length exactly 2^ADDR_W is legal; abort it with reset.
        start_load();
        stream = '{8'h00, 8'h08};
        send_stream(0);
        check_eq("max_flags", {err, rx_ready, busy}, 32'h3);
        check_eq("max_wcnt", 32'(word_count), 32'h800);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_outputs("max_rst");

        // Same two-word stream with a bubble after every byte.
        clear_log();
        start_load();
        stream = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_stream(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'h88, 1);
`endif
        wait_done("bub_done");
        check_eq("bub_nwr", 32'(wr_data.size()), 32'd2);
        if (wr_data.size() == 2) begin
            check_eq("bub_d0", wr_data[0], 32'h44332211);
            check_eq("bub_a1", 32'(wr_addr[1]), 32'd1);
            check_eq("bub_d1", wr_data[1], 32'h88776655);
        end

        // Reset two bytes into the first word.
        clear_log();
        start_load();
        stream = '{8'h01, 8'h00, 8'h11, 8'h22};
        send_stream(0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_outputs("mid_rst_flags");
        check_eq("mid_rst_addr", 32'(mem_addr), 32'd0);
        check_eq("mid_rst_data", mem_data, 32'd0);
        check_eq("mid_rst_wcnt", 32'(word_count), 32'd0);
        repeat (4) step();
        check_eq("mid_rst_nwr", 32'(wr_data.size()), 32'd0);
        check_idle_outputs("mid_rst_idle");

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        clear_log();
        start_load();
        stream = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        send_stream(0);
        wait_done("csum_ok_done");
        check_eq("csum_ok_d0", wr_data.size() == 1 ? wr_data[0] : 32'hX, 32'h04030201);

        clear_log();
        start_load();
        stream = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_stream(0);
        check_eq("csum_bad_flags", {err, cpu_hold, done}, 32'h6);
        check_eq("csum_bad_nwr", 32'(wr_data.size()), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
